// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer: steps each instruction through
// fetch/decode/execute/memory/writeback, decodes datapath control lines
// from the current state, stalls on the memory handshake and counts
// retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [3:0]       imm_func,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;
  logic             retire;

  // ALU function code for the supported I-type instructions.
  function automatic logic [3:0] imm_code(input logic [5:0] op);
    case (op)
      OP_ADDI: imm_code = 4'b0010;
      OP_ANDI: imm_code = 4'b0000;
      OP_ORI:  imm_code = 4'b0001;
      OP_SLTI: imm_code = 4'b0111;
      default: imm_code = 4'b0000;
    endcase
  endfunction

  // State, latched opcode and retired-instruction counter registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      opcode_q      <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state logic and Moore decode of the datapath control lines.
  // NOTE: every output is given a default before the case so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    retire     = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_func   = 4'b0000;
    pc_source  = 2'b00;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        opcode_d  = opcode;
        case (opcode)
          OP_RTYPE:                          state_d = S_R_EXEC;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pc_write  = (opcode_q == OP_BEQ) ? zero : ~zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        imm_func  = imm_code(opcode_q);
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        // ALU operation held from I_EXEC so the result stays stable on writeback.
        alu_op    = 2'b11;
        imm_func  = imm_code(opcode_q);
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle pushes the
// expected state, control vector, illegal flag and count; a negedge
// monitor pops and compares.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4,
                         MW = 4'd5, RX = 4'd6, RW = 4'd7, BR = 4'd8, JP = 4'd9,
                         IX = 4'd10, IW = 4'd11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic zero = 1'b0;
  logic mem_ready = 1'b0;
  logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, mem_to_reg;
  logic reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] imm_func, state;
  logic [CNT_W-1:0] instr_count;

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_func(imm_func), .pc_source(pc_source), .state(state),
    .illegal(illegal), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [18:0] act_ctrl;
  assign act_ctrl = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst,
                     mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                     imm_func, pc_source};

  typedef struct {
    string            tag;
    logic [3:0]       st;
    logic [18:0]      ctrl;
    logic             ill;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [5:0] cur_op = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010,
      6'b001000, 6'b001100, 6'b001101, 6'b001010: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] imm_of(input logic [5:0] op);
    case (op)
      6'b001000: imm_of = 4'b0010;
      6'b001100: imm_of = 4'b0000;
      6'b001101: imm_of = 4'b0001;
      6'b001010: imm_of = 4'b0111;
      default:   imm_of = 4'b0000;
    endcase
  endfunction

  // Expected control vector for a state, written from the state table.
  function automatic logic [18:0] spec_ctrl(input logic [3:0] st, input logic mr,
                                            input logic z, input logic [5:0] lat);
    logic pcw, irw, iod, mrd, mwr, rd, m2r, rw, sa;
    logic [1:0] sb, op, pcs;
    logic [3:0] imm;
    {pcw, irw, iod, mrd, mwr, rd, m2r, rw, sa} = '0;
    sb = 2'b00; op = 2'b00; pcs = 2'b00; imm = 4'b0000;
    case (st)
      F:   begin mrd = 1'b1; sb = 2'b01; pcw = mr; irw = mr; end
      D:   sb = 2'b11;
      MA:  begin sa = 1'b1; sb = 2'b10; end
      MR:  begin mrd = 1'b1; iod = 1'b1; end
      MWB: begin rw = 1'b1; m2r = 1'b1; end
      MW:  begin mwr = 1'b1; iod = 1'b1; end
      RX:  begin sa = 1'b1; op = 2'b10; end
      RW:  begin rw = 1'b1; rd = 1'b1; end
      BR:  begin sa = 1'b1; op = 2'b01; pcs = 2'b01; pcw = (lat == 6'b000100) ? z : ~z; end
      JP:  begin pcw = 1'b1; pcs = 2'b10; end
      IX:  begin sa = 1'b1; sb = 2'b10; op = 2'b11; imm = imm_of(lat); end
      IW:  begin rw = 1'b1; op = 2'b11; imm = imm_of(lat); end
      default: ;
    endcase
    spec_ctrl = {pcw, irw, iod, mrd, mwr, rd, m2r, rw, sa, sb, op, imm, pcs};
  endfunction

  // One stimulus cycle: drive inputs after the edge and queue the expectation.
  task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] op,
                      input logic z, input logic retire, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = mr;
    opcode    = op;
    zero      = z;
    e.tag  = tag;
    e.st   = st;
    e.ctrl = spec_ctrl(st, mr, z, cur_op);
    e.ill  = (st == D) && !legal(op);
    e.cnt  = exp_cnt;
    q.push_back(e);
    if (st == D) cur_op = op;
    if (retire) exp_cnt = exp_cnt + 1'b1;
  endtask

  // Monitor: compare the DUT against the oldest expectation every cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.tag, ".state"}, 32'(state), 32'(e.st));
      check({e.tag, ".ctrl"}, 32'(act_ctrl), 32'(e.ctrl));
      check({e.tag, ".illegal"}, 32'(illegal), 32'(e.ill));
      check({e.tag, ".count"}, 32'(instr_count), 32'(e.cnt));
    end
  end

  initial begin
    exp_t e0;
    // Reset state with mem_ready low: FETCH decode, no pc_write/ir_write.
    e0.tag = "reset"; e0.st = F; e0.ctrl = spec_ctrl(F, 1'b0, 1'b0, 6'd0);
    e0.ill = 1'b0; e0.cnt = '0;
    q.push_back(e0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // R-type: 0,1,6,7 then count 1; mem_ready high outside memory states is ignored.
    step(F,  1, 6'b000000, 0, 0, "r_f");
    step(D,  1, 6'b000000, 0, 0, "r_d");
    step(RX, 1, 6'b000000, 0, 0, "r_ex");
    step(RW, 1, 6'b000000, 0, 1, "r_wb");

    // lw with one FETCH wait and two MEM_RD waits.
    step(F,   0, 6'b100011, 0, 0, "lw_fwait");
    step(F,   1, 6'b100011, 0, 0, "lw_f");
    step(D,   0, 6'b100011, 0, 0, "lw_d");
    step(MA,  0, 6'b100011, 0, 0, "lw_ma");
    step(MR,  0, 6'b100011, 0, 0, "lw_rd_w1");
    step(MR,  0, 6'b100011, 0, 0, "lw_rd_w2");
    step(MR,  1, 6'b100011, 0, 0, "lw_rd");
    step(MWB, 0, 6'b100011, 0, 1, "lw_wb");

    // beq taken, beq not taken, bne taken.
    step(F,  1, 6'b000100, 1, 0, "beq1_f");
    step(D,  0, 6'b000100, 1, 0, "beq1_d");
    step(BR, 0, 6'b000100, 1, 1, "beq1_br");
    step(F,  1, 6'b000100, 0, 0, "beq0_f");
    step(D,  0, 6'b000100, 0, 0, "beq0_d");
    step(BR, 0, 6'b000100, 0, 1, "beq0_br");
    step(F,  1, 6'b000101, 0, 0, "bne0_f");
    step(D,  0, 6'b000101, 0, 0, "bne0_d");
    step(BR, 0, 6'b000101, 0, 1, "bne0_br");

    // ori and slti.
    step(F,  1, 6'b001101, 0, 0, "ori_f");
    step(D,  0, 6'b001101, 0, 0, "ori_d");
    step(IX, 0, 6'b001101, 0, 0, "ori_ex");
    step(IW, 0, 6'b001101, 0, 1, "ori_wb");
    step(F,  1, 6'b001010, 0, 0, "slti_f");
    step(D,  0, 6'b001010, 0, 0, "slti_d");
    step(IX, 0, 6'b001010, 0, 0, "slti_ex");
    step(IW, 0, 6'b001010, 0, 1, "slti_wb");

    // sw, no waits.
    step(F,  1, 6'b101011, 0, 0, "sw_f");
    step(D,  0, 6'b101011, 0, 0, "sw_d");
    step(MA, 0, 6'b101011, 0, 0, "sw_ma");
    step(MW, 1, 6'b101011, 0, 1, "sw_wr");

    // Jumps carry the 4-bit counter from 8 through 15 and wrap to 0.
    for (int i = 0; i < 8; i++) begin
      step(F,  1, 6'b000010, 0, 0, "j_f");
      step(D,  0, 6'b000010, 0, 0, "j_d");
      step(JP, 0, 6'b000010, 0, 1, "j_jp");
    end

    // Illegal opcode: pulse in DECODE, back to FETCH, count unchanged.
    step(F, 1, 6'b111111, 0, 0, "ill_f");
    step(D, 1, 6'b111111, 0, 0, "ill_d");

    // R-type after the wrap so the counter is nonzero.
    step(F,  1, 6'b000000, 0, 0, "r2_f");
    step(D,  0, 6'b000000, 0, 0, "r2_d");
    step(RX, 0, 6'b000000, 0, 0, "r2_ex");
    step(RW, 0, 6'b000000, 0, 1, "r2_wb");

    // sw stalled in MEM_WR, then reset mid-cycle.
    step(F,  1, 6'b101011, 0, 0, "swr_f");
    step(D,  0, 6'b101011, 0, 0, "swr_d");
    step(MA, 0, 6'b101011, 0, 0, "swr_ma");
    step(MW, 0, 6'b101011, 0, 0, "swr_wait");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst.state", 32'(state), 32'(F));
    check("async_rst.mem_write", 32'(mem_write), 32'(0));
    check("async_rst.count", 32'(instr_count), 32'(0));
    check("async_rst.reg_write", 32'(reg_write), 32'(0));
    exp_cnt = '0;
    cur_op  = '0;
    @(posedge clk);
    #1 reset = 1'b0;

    // Recovery: fresh R-type counts from zero.
    step(F,  1, 6'b000000, 0, 0, "r3_f");
    step(D,  0, 6'b000000, 0, 0, "r3_d");
    step(RX, 0, 6'b000000, 0, 0, "r3_ex");
    step(RW, 0, 6'b000000, 0, 1, "r3_wb");
    step(F,  0, 6'b000000, 0, 0, "r3_done");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS datapath. It walks each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath control lines one state at a time. It stalls on a memory ready handshake and counts retired instructions. It sits between the instruction register/opcode field, the ALU zero flag, the memory interface and the datapath muxes/enables.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces FETCH and clears counters
- opcode  in  6  instruction[31:26], valid from the cycle after IR is written
- zero  in  1  ALU zero flag, sampled in BRANCH
- mem_ready  in  1  memory handshake, completes a FETCH/MEM_RD/MEM_WR access
- pc_write  out  1  PC load enable (already gated with branch condition)
- ir_write  out  1  instruction register load
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- mem_read, mem_write  out  1 each  memory strobes
- reg_dst, mem_to_reg, reg_write  out  1 each  register file controls
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct decode, 11 use imm_func
- imm_func  out  4  ALU code for I-type: addi 0010, andi 0000, ori 0001, slti 0111
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- state  out  4  current state encoding (debug)
- illegal  out  1  one-cycle pulse on an unsupported opcode
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States (4-bit encoding): FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11.
- Outputs are a Moore decode of the state register, except pc_write in FETCH (gated by mem_ready) and pc_write in BRANCH (gated by zero).
- Any output not listed for a state is 0.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. When mem_ready=1: ir_write=1, pc_write=1, next DECODE. Otherwise hold.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. The opcode is latched into an internal register; later states use only the latched copy.
- Next state from DECODE:
  - 000000 → R_EXEC
  - 100011 or 101011 → MEM_ADDR
  - 000100 or 000101 → BRANCH
  - 000010 → JUMP
  - 001000, 001100, 001101, 001010 → I_EXEC
  - anything else → illegal=1 for one cycle, next FETCH, counter unchanged
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Hold until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Then R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. pc_write = zero for beq, ~zero for bne. Next FETCH.
- JUMP: pc_write=1, pc_source=10. Next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, imm_func from the latched opcode. Then I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, imm_func held. Next FETCH.
- instr_count increments by 1 on the last cycle of every legal instruction: MEM_WB, MEM_WR with mem_ready, R_WB, BRANCH, JUMP, I_WB.

## Timing
- Reset (asynchronous): state=FETCH, latched opcode=0, instr_count=0, illegal=0. All outputs take their FETCH decode; pc_write/ir_write stay 0 while mem_ready=0.
- Latency with zero wait states:
  - lw: 5 cycles
  - R-type, sw, I-type: 4 cycles
  - beq/bne, j: 3 cycles
  - illegal opcode: 2 cycles
- Each memory wait cycle adds exactly 1 cycle; strobes and the address select stay stable while waiting.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-instruction aborts it: no reg_write/mem_write after reset, no count.
- instr_count wraps from all-ones to 0 with no flag.

## Test plan
- Reset released, mem_ready=1, opcode=000000: states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. instr_count=1 after 4 cycles.
- lw (100011), mem_ready held low for 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0. mem_read and i_or_d stable through the waits. Total 7 cycles.
- beq with zero=1, then beq with zero=0, then bne with zero=0: pc_write in BRANCH is 1, 0, 1. pc_source=01 each time.
- ori (001101): imm_func=0001 and alu_op=11 in I_EXEC and I_WB, reg_write=1 in I_WB only.
- Illegal opcode 111111: illegal pulses once in DECODE, next state FETCH, instr_count unchanged.
- Reset asserted in MEM_WR while mem_ready=0: state immediately 0, mem_write=0, instr_count=0.
